// File: rtl/mem_refill_pkg.sv
// Shared types and constants for the cache miss refill controller.
package mem_refill_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   localparam logic [DEF_ADDR_W-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WB_REQ = 2'd1,
      RD_REQ = 2'd2,
      FILL   = 2'd3
   } refill_state_e;

endpackage

// File: rtl/mem_refill_ctrl_watchdog.sv
// Stall watchdog for one memory transfer; counts req cycles without ack.
module refill_watchdog #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic mem_req,
   input  logic mem_ack,
   output logic timeout
);

   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [CNT_W-1:0] cnt_q;

   // Clearing whenever mem_req is low covers IDLE and FILL alike.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (!mem_req || mem_ack) begin
         cnt_q <= '0;
      end else if (!timeout) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC));

endmodule

// File: rtl/mem_refill_ctrl.sv
// Miss refill sequencer: optional dirty write-back, then word read, then fill pulse.
// Optional stall watchdog enabled by defining REFILL_TIMEOUT_EN.
module mem_refill_ctrl
   import mem_refill_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              miss_req,
   input  logic [ADDR_W-1:0] miss_addr,
   input  logic              victim_dirty,
   input  logic [ADDR_W-1:0] victim_addr,
   input  logic [DATA_W-1:0] victim_data,
   output logic              busy,
   output logic              fill_valid,
   output logic [DATA_W-1:0] fill_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err
);

   refill_state_e     state_q, state_d;
   logic [ADDR_W-1:0] miss_addr_q, victim_addr_q, addr_sel;
   logic [DATA_W-1:0] victim_data_q;
   logic              expire;

`ifdef REFILL_TIMEOUT_EN
   logic wd_timeout;
   logic err_q;

   refill_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .mem_req (mem_req),
      .mem_ack (mem_ack),
      .timeout (wd_timeout)
   );

   assign expire = wd_timeout && mem_req && !mem_ack;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      err_q <= 1'b0;
      else if (expire) err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign expire = 1'b0;
   assign err    = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (miss_req) state_d = victim_dirty ? WB_REQ : RD_REQ;
         WB_REQ:  if (mem_ack) state_d = RD_REQ; else if (expire) state_d = FILL;
         RD_REQ:  if (mem_ack || expire) state_d = FILL;
         FILL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         miss_addr_q   <= '0;
         victim_addr_q <= '0;
         victim_data_q <= '0;
         fill_data     <= '0;
      end else begin
         if (state_q == IDLE && miss_req) begin
            miss_addr_q   <= miss_addr;
            victim_addr_q <= victim_addr;
            victim_data_q <= victim_data;
         end
         if (state_q == RD_REQ && mem_ack) fill_data <= mem_rdata;
         else if (expire)                 fill_data <= '0;
      end
   end

   always_comb begin
      busy       = (state_q != IDLE);
      mem_req    = (state_q == WB_REQ) || (state_q == RD_REQ);
      mem_we     = (state_q == WB_REQ);
      fill_valid = (state_q == FILL);
      addr_sel   = (state_q == WB_REQ) ? victim_addr_q : miss_addr_q;
      mem_addr   = {addr_sel[ADDR_W-1:2], addr_sel[1:0] & WORD_ALIGN_MASK[1:0]};
      mem_wdata  = victim_data_q;
   end

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Scoreboard bench for mem_refill_ctrl; timeout scenario runs when REFILL_TIMEOUT_EN is defined.
module tb_mem_refill_ctrl;

   localparam int TMO = 4;

   typedef struct {
      int          kind;     // 0 write, 1 read, 2 fill
      logic [31:0] addr;
      logic [31:0] data;
      int          edge_at;
   } exp_t;

   typedef struct {
      int          w;
      logic [31:0] rd;
   } resp_t;

   logic        clk, reset;
   logic        miss_req, victim_dirty;
   logic [31:0] miss_addr, victim_addr, victim_data;
   logic        busy, fill_valid, mem_req, mem_we, mem_ack, err;
   logic [31:0] fill_data, mem_addr, mem_wdata, mem_rdata;

   exp_t  expq[$];
   resp_t respq[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    edge_n = 0;
   bit    err_exp = 0;

   mem_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
      .clk          (clk),
      .reset        (reset),
      .miss_req     (miss_req),
      .miss_addr    (miss_addr),
      .victim_dirty (victim_dirty),
      .victim_addr  (victim_addr),
      .victim_data  (victim_data),
      .busy         (busy),
      .fill_valid   (fill_valid),
      .fill_data    (fill_data),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .err          (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory responder: acks after the scripted wait count, and sprinkles acks while idle.
   initial begin
      bit    active;
      int    n;
      resp_t r;
      active = 0; n = 0; r.w = 0; r.rd = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (mem_req) begin
            if (!active) begin
               active = 1; n = 0;
               if (respq.size() > 0) r = respq.pop_front();
               else begin r.w = 0; r.rd = '0; end
            end
            if (n >= r.w) begin
               mem_ack = 1'b1; mem_rdata = r.rd; active = 0;
            end else begin
               n++; mem_rdata = $urandom;
            end
         end else begin
            active = 0;
            mem_ack = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
         end
      end
   end

   // Monitor: pops the scoreboard on each completed transfer or fill pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #1;
         if (mem_req && mem_ack) begin
            if (expq.size() == 0) chk("unexpected_xfer", 1, 0);
            else begin
               e = expq.pop_front();
               chk("xfer_kind", (e.kind == 2) ? 64'd2 : 64'(mem_we ? 0 : 1), e.kind);
               chk("xfer_addr", mem_addr, e.addr);
               if (e.kind == 0) chk("xfer_wdata", mem_wdata, e.data);
            end
         end
         if (fill_valid) begin
            if (expq.size() == 0) chk("unexpected_fill", 1, 0);
            else begin
               e = expq.pop_front();
               chk("fill_kind", 2, e.kind);
               chk("fill_data", fill_data, e.data);
               chk("fill_latency_edge", edge_n, e.edge_at);
            end
         end
      end
   end

   // Expected events for one miss whose sample edge is s; latency counted from s.
   task automatic push_txn(input int s, input bit dirty, input bit tmo,
                           input logic [31:0] ma, input logic [31:0] va, input logic [31:0] vd,
                           input int ww, input int rw, input logic [31:0] rd, output int lat);
      resp_t r;
      if (tmo) begin
         r.w = 1000; r.rd = $urandom; respq.push_back(r);
         lat = TMO + 2;
         expq.push_back('{2, 32'h0, 32'h0, s + lat - 1});
         return;
      end
      if (dirty) begin
         r.w = ww; r.rd = $urandom; respq.push_back(r);
         expq.push_back('{0, va & ~32'h3, vd, 0});
      end
      r.w = rw; r.rd = rd; respq.push_back(r);
      expq.push_back('{1, ma & ~32'h3, 32'h0, 0});
      lat = dirty ? (3 + ww + rw) : (2 + rw);
      expq.push_back('{2, 32'h0, rd, s + lat - 1});
   endtask

   task automatic wait_idle();
      int k = 0;
      @(negedge clk);
      while (busy && k < 300) begin @(negedge clk); k++; end
      if (busy) chk("wait_idle_timeout", 1, 0);
   endtask

   task automatic wait_edge(input int t);
      int k = 0;
      while (edge_n < t && k < 1000) begin @(negedge clk); k++; end
      if (edge_n < t) chk("wait_edge_timeout", edge_n, t);
   endtask

   task automatic drive(input bit dirty, input logic [31:0] ma, input logic [31:0] va,
                        input logic [31:0] vd);
      miss_req = 1'b1; victim_dirty = dirty;
      miss_addr = ma; victim_addr = va; victim_data = vd;
   endtask

   task automatic issue(input bit dirty, input bit tmo, input logic [31:0] ma, input logic [31:0] va,
                        input logic [31:0] vd, input int ww, input int rw, input logic [31:0] rd);
      int s, lat;
      wait_idle();
      s = edge_n + 1;
      drive(dirty, ma, va, vd);
      push_txn(s, dirty, tmo, ma, va, vd, ww, rw, rd, lat);
      wait_edge(s);
      miss_req = 1'b0;
      wait_idle();
      if (tmo) err_exp = 1;
      chk("err_after_txn", err, err_exp);
   endtask

   initial begin
      int s1, s2, l1, l2, s;
      reset = 1'b0; miss_req = 1'b0; victim_dirty = 1'b0;
      miss_addr = '0; victim_addr = '0; victim_data = '0;
      @(negedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_fill_valid", fill_valid, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_err", err, 0);
      chk("rst_fill_data", fill_data, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      @(negedge clk);
      reset = 1'b1;

      issue(0, 0, 32'h0000_0104, 32'h0, 32'h0, 0, 0, 32'hDEAD_BEEF);
      issue(1, 0, 32'h0000_0300, 32'h0000_0200, 32'h1234_5678, 2, 2, 32'hCAFE_F00D);
      issue(0, 0, 32'h0000_0107, 32'h0, 32'h0, 0, 1, 32'h0BAD_CAFE);

      // miss_req held through FILL: a second transaction follows after one idle cycle
      wait_idle();
      s1 = edge_n + 1;
      drive(0, 32'h0000_0440, 32'h0, 32'h0);
      push_txn(s1, 0, 0, 32'h0000_0440, 32'h0, 32'h0, 0, 1, 32'h1111_2222, l1);
      s2 = s1 + l1 + 1;
      push_txn(s2, 1, 0, 32'h0000_0551, 32'h0000_0662, 32'h3333_4444, 1, 0, 32'h5555_6666, l2);
      wait_edge(s1 + l1);
      chk("gap_busy_low", busy, 0);
      drive(1, 32'h0000_0551, 32'h0000_0662, 32'h3333_4444);
      wait_edge(s2);
      chk("gap_busy_high_again", busy, 1);
      miss_req = 1'b0;
      wait_idle();

`ifdef REFILL_TIMEOUT_EN
      issue(0, 1, 32'h0000_0800, 32'h0, 32'h0, 0, 0, 32'h0);
      issue(0, 0, 32'h0000_0900, 32'h0, 32'h0, 0, 0, 32'h7777_8888);
`endif

      // Reset during a stalled read aborts without a fill
      wait_idle();
      s = edge_n + 1;
      drive(0, 32'h0000_0A00, 32'h0, 32'h0);
      begin
         resp_t r;
         r.w = 20; r.rd = 32'hFFFF_0000;
         respq.push_back(r);
      end
      wait_edge(s);
      miss_req = 1'b0;
      wait_edge(s + 3);
      chk("pre_abort_mem_req", mem_req, 1);
      #2 reset = 1'b0;
      #1;
      err_exp = 0;
      chk("abort_mem_req", mem_req, 0);
      chk("abort_busy", busy, 0);
      chk("abort_fill_valid", fill_valid, 0);
      chk("abort_err", err, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 30; i++) begin
         issue($urandom_range(0, 1), 0, $urandom, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end

      for (int k = 0; k < 50 && expq.size() > 0; k++) @(negedge clk);
      chk("scoreboard_drained", expq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_refill_ctrl.md
Name: mem_refill_ctrl

Overview:
Miss-handling stage directly downstream of the 2-way data cache; it consumes the cache's miss and dirty-victim outputs. Sequences an optional dirty-victim write-back, then a line (word) read from main memory over a req/ack handshake. Returns the fill word to the cache with a one-cycle valid pulse. Holds busy high for the whole transaction so the pipeline stalls.

Parameters:
ADDR_W, 32, byte address width on both cache and memory sides
DATA_W, 32, data word width
TIMEOUT_CYC, 255, watchdog limit in cycles per memory transfer (used only with the optional feature)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
miss_req  in  1  cache miss; sampled only in IDLE
miss_addr  in  ADDR_W  byte address of missed word
victim_dirty  in  1  evicted way is dirty; write back first
victim_addr  in  ADDR_W  byte address of victim word
victim_data  in  DATA_W  victim word
busy  out  1  transaction in progress; cache must hold inputs stable and not issue miss_req
fill_valid  out  1  one-cycle pulse, fill_data valid
fill_data  out  DATA_W  word read from memory
mem_req  out  1  memory request; held until mem_ack
mem_we  out  1  1 = write, 0 = read; stable while mem_req
mem_addr  out  ADDR_W  word-aligned memory address, bits [1:0] forced to 0
mem_wdata  out  DATA_W  write data
mem_ack  in  1  memory completes transfer on this edge
mem_rdata  in  DATA_W  read data, valid when mem_ack high on a read
err  out  1  sticky watchdog error (constant 0 when feature off)

Behaviour:
- Reset (reset low, asynchronous): state IDLE; busy, fill_valid, mem_req, mem_we, err = 0; fill_data, mem_addr, mem_wdata = 0.
- Reset asserted mid-transaction aborts immediately. mem_req drops with no completion. The cache re-issues the miss after reset.
- FSM states: IDLE, WB_REQ, RD_REQ, FILL.
- IDLE, miss_req = 1, victim_dirty = 1:
  - Latch miss_addr, victim_addr, victim_data.
  - Next cycle: WB_REQ with mem_req = 1, mem_we = 1, mem_addr = victim_addr, mem_wdata = victim_data.
- IDLE, miss_req = 1, victim_dirty = 0:
  - Go to RD_REQ with mem_req = 1, mem_we = 0, mem_addr = miss_addr.
- busy is registered and goes high the cycle after miss_req is sampled. It stays high through FILL and drops on return to IDLE.
- WB_REQ: on an edge with mem_ack = 1, go directly to RD_REQ. mem_req stays high (back-to-back), mem_we becomes 0, and the address switches to miss_addr.
- RD_REQ: on an edge with mem_ack = 1, capture mem_rdata into fill_data and go to FILL.
- FILL: fill_valid = 1 for exactly one cycle, mem_req = 0, then IDLE. fill_data holds its value until the next fill.
- mem_ack while mem_req = 0 is ignored. mem_rdata is ignored on write acks.
- Latency with zero memory wait (ack in the first req cycle):
  - Clean miss: fill_valid is high 2 cycles after the miss_req sample edge.
  - Dirty miss: 3 cycles.
  - Each wait cycle adds 1.
- miss_req in IDLE while the same-cycle FILL is finishing cannot occur: the FSM is in FILL, not IDLE. A miss_req held high through FILL is re-sampled in IDLE and starts a new transaction.
- Addresses pass through unshifted except bits [1:0] cleared.

Optional Feature:
Macro REFILL_TIMEOUT_EN.
- With it: an 8-bit-min counter, sized $clog2(TIMEOUT_CYC+1), increments each cycle mem_req = 1 && mem_ack = 0. It clears on ack or in IDLE.
- On reaching TIMEOUT_CYC the block:
  - sets err (sticky until reset);
  - drops mem_req;
  - pulses fill_valid with fill_data = 0;
  - returns to IDLE.
- Without it: no counter; err tied to 0; the block waits forever for mem_ack.

Decomposition:
- Package mem_refill_pkg holds:
  - the state enum (IDLE, WB_REQ, RD_REQ, FILL, 2-bit encoding);
  - the ADDR_W/DATA_W defaults;
  - the WORD_ALIGN_MASK constant.
- One sub-module: refill_watchdog (counter + compare, present only under REFILL_TIMEOUT_EN). Everything else stays flat in mem_refill_ctrl.

Test Plan:
- Clean miss: miss_addr = 0x0000_0104, victim_dirty = 0, mem_ack in first req cycle, mem_rdata = 0xDEAD_BEEF -> one read at mem_addr 0x104, fill_valid 2 cycles after sample, fill_data = 0xDEAD_BEEF.
- Dirty miss: victim_addr = 0x0000_0200, victim_data = 0x1234_5678, miss_addr = 0x0000_0300, 2 wait cycles on each transfer -> write 0x1234_5678 @0x200, then read @0x300; mem_req never drops between them; fill_valid 7 cycles after sample.
- Unaligned address 0x0000_0107 -> mem_addr = 0x0000_0104.
- Spurious mem_ack in IDLE plus miss_req held high through FILL -> spurious ack ignored; second transaction starts cleanly; busy low for exactly one cycle between transactions.
- Reset pulled low during RD_REQ wait -> mem_req, busy = 0 asynchronously; no fill_valid; next miss works normally.
- REFILL_TIMEOUT_EN, TIMEOUT_CYC = 4, mem_ack never asserted -> after 4 stalled cycles err = 1, fill_valid pulses with fill_data = 0, FSM returns to IDLE; err stays 1 until reset.
